// File: rtl/eth_frame_detector_pkg.sv
// Shared types for the frame detector stream stage: detection record, stream FSM states,
// drop counter width and the helper that packs beat 3.
package eth_frame_detector_pkg;

  localparam int FD_DROP_CNT_W = 16;

  // "time" is a reserved word, so the timestamp field is time_stamp
  typedef struct packed {
    logic [63:0] time_stamp;
    logic [5:0]  ids;
    logic [5:0]  matched;
  } fd_record_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B1   = 2'd1,
    B2   = 2'd2,
    B3   = 2'd3
  } fd_stream_state_t;

  function automatic logic [31:0] fd_b3_word(input logic [FD_DROP_CNT_W-1:0] drop_cnt,
                                             input fd_record_t rec);
    return {drop_cnt, 4'b0000, rec.ids, rec.matched};
  endfunction

endpackage

// File: rtl/eth_frame_detector_stream_fifo.sv
// Synchronous record FIFO, registered read (one cycle after pop), synchronous flush.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module eth_frame_detector_stream_fifo
  import eth_frame_detector_pkg::*;
#(
  parameter int depth = 64,
  localparam int AW = $clog2(depth)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        push,
  input  fd_record_t  wr_data,
  input  logic        pop,
  output fd_record_t  rd_data,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(depth);

  fd_record_t    mem [depth];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/eth_frame_detector_stream.sv
// Turns match strobes into timestamped records, buffers them and emits 3-beat AXI4-Stream packets.
// Optional FD_STREAM_MATCH_ID_EN adds match_a_id/match_b_id inputs carried in beat 3.
//   state | meaning
//   IDLE  | no record in the output register, waiting for the FIFO
//   B1    | presenting time[31:0]
//   B2    | presenting time[63:32]
//   B3    | presenting drop count, ids, matched flags (tlast)
module eth_frame_detector_stream
  import eth_frame_detector_pkg::*;
#(
  parameter int fifo_depth = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         srst,
  input  logic                         enable,
  input  logic [2:0]                   match_a,
  input  logic [2:0]                   match_b,
`ifdef FD_STREAM_MATCH_ID_EN
  input  logic [1:0]                   match_a_id,
  input  logic [1:0]                   match_b_id,
`endif
  input  logic [63:0]                  current_time,
  input  logic                         time_running,
  output logic [31:0]                  m_axis_tdata,
  output logic                         m_axis_tlast,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [$clog2(fifo_depth):0]  fifo_occupancy,
  output logic                         overflow
);

  fd_stream_state_t         state;
  fd_stream_state_t         state_nxt;
  fd_record_t               wr_rec;
  fd_record_t               out_rec;
  logic [5:0]               matched;
  logic [5:0]               ids;
  logic                     event_hit;
  logic                     pop;
  logic                     full;
  logic                     empty;
  logic                     drop;
  logic [FD_DROP_CNT_W-1:0] drop_cnt;
  logic [FD_DROP_CNT_W-1:0] out_drop_cnt;

  assign matched   = {match_b, match_a};
  assign event_hit = enable & time_running & (|matched);
`ifdef FD_STREAM_MATCH_ID_EN
  assign ids = {2'b00, match_b_id, match_a_id};
`else
  assign ids = '0;
`endif
  assign wr_rec = '{time_stamp: current_time, ids: ids, matched: matched};
  assign drop   = event_hit & full & ~pop;

  // The FIFO read register doubles as the output record register.
  eth_frame_detector_stream_fifo #(
    .depth (fifo_depth)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (srst),
    .push    (event_hit),
    .wr_data (wr_rec),
    .pop     (pop),
    .rd_data (out_rec),
    .full    (full),
    .empty   (empty),
    .count   (fifo_occupancy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (srst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!empty) state_nxt = B1;
      B1:   if (m_axis_tready) state_nxt = B2;
      B2:   if (m_axis_tready) state_nxt = B3;
      B3:   if (m_axis_tready) state_nxt = empty ? IDLE : B1;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop           = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    case (state)
      IDLE: pop = ~empty;
      B1: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = out_rec.time_stamp[31:0];
      end
      B2: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = out_rec.time_stamp[63:32];
      end
      B3: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        m_axis_tdata  = fd_b3_word(out_drop_cnt, out_rec);
        pop           = m_axis_tready & ~empty;
      end
      default: ;
    endcase
  end

  // Drop count is handed to the record being loaded and restarts from this cycle's drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt     <= '0;
      out_drop_cnt <= '0;
      overflow     <= 1'b0;
    end else if (srst) begin
      drop_cnt     <= '0;
      out_drop_cnt <= '0;
      overflow     <= 1'b0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (pop) begin
        out_drop_cnt <= drop_cnt;
        drop_cnt     <= {{(FD_DROP_CNT_W-1){1'b0}}, drop};
      end else if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_eth_frame_detector_stream.sv
// Self-checking bench for eth_frame_detector_stream (fifo_depth=4): vector table plus
// hand-written timing, backpressure, overflow and srst sequences, scoreboard on AXIS beats.
module tb_eth_frame_detector_stream;
  import eth_frame_detector_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, srst, enable, time_running, m_axis_tready;
  logic [2:0]  match_a, match_b;
  logic [63:0] current_time;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast, m_axis_tvalid, overflow;
  logic [2:0]  fifo_occupancy;
`ifdef FD_STREAM_MATCH_ID_EN
  logic [1:0]  match_a_id = 2'b00;
  logic [1:0]  match_b_id = 2'b00;
`endif

  always #5 clk = ~clk;

  eth_frame_detector_stream #(.fifo_depth(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .srst           (srst),
    .enable         (enable),
    .match_a        (match_a),
    .match_b        (match_b),
`ifdef FD_STREAM_MATCH_ID_EN
    .match_a_id     (match_a_id),
    .match_b_id     (match_b_id),
`endif
    .current_time   (current_time),
    .time_running   (time_running),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .fifo_occupancy (fifo_occupancy),
    .overflow       (overflow)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic [2:0]  a;
    logic [2:0]  b;
    logic        en;
    logic        run;
    logic [63:0] t;
    logic        kept;
  } vec_t;

  beat_t exp_q[$];
  vec_t  vecs[8];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every handshaken beat is compared against the oldest expected beat.
  always @(negedge clk) begin
    if (!rst_n || srst) begin
      exp_q.delete();
    end else if (m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: got 0x%0h, want no beat", m_axis_tdata);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat_data", m_axis_tdata, e.data);
        check("beat_last", m_axis_tlast, e.last);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; strobes are held for exactly one cycle.
  task automatic fire(input logic [2:0] a, input logic [2:0] b, input logic en, input logic run,
                      input logic [63:0] t, input logic kept, input logic [15:0] dcnt);
    beat_t bt;
    enable       = en;
    time_running = run;
    match_a      = a;
    match_b      = b;
    current_time = t;
    if (kept) begin
      bt.data = t[31:0];  bt.last = 1'b0; exp_q.push_back(bt);
      bt.data = t[63:32]; bt.last = 1'b0; exp_q.push_back(bt);
      bt.data = {dcnt, 4'b0000, 6'b000000, b, a}; bt.last = 1'b1; exp_q.push_back(bt);
    end
    step(1);
    match_a = 3'b000;
    match_b = 3'b000;
    enable  = 1'b1;
    time_running = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && k < budget) begin
      step(1);
      k++;
    end
    if (k >= budget) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d beats pending, want 0", name, exp_q.size());
    end else begin
      check({name, "_occ"}, fifo_occupancy, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; srst = 1'b0; enable = 1'b1; time_running = 1'b1; m_axis_tready = 1'b1;
    match_a = 3'b000; match_b = 3'b000; current_time = '0;

    vecs[0] = '{3'b001, 3'b000, 1'b1, 1'b1, 64'h0000_0001_0000_0010, 1'b1};
    vecs[1] = '{3'b100, 3'b010, 1'b1, 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1};
    vecs[2] = '{3'b000, 3'b111, 1'b1, 1'b1, 64'h0000_0000_FFFF_FFFF, 1'b1};
    vecs[3] = '{3'b000, 3'b000, 1'b1, 1'b1, 64'h0000_0000_0000_0333, 1'b0};
    vecs[4] = '{3'b011, 3'b000, 1'b0, 1'b1, 64'h0000_0000_0000_0444, 1'b0};
    vecs[5] = '{3'b010, 3'b001, 1'b1, 1'b0, 64'h0000_0000_0000_0555, 1'b0};
    vecs[6] = '{3'b111, 3'b111, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[7] = '{3'b000, 3'b001, 1'b1, 1'b1, 64'hA5A5_0000_0000_5A5A, 1'b1};

    step(3);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_occ", fifo_occupancy, 0);
    check("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    step(2);
    check("post_rst_tvalid", m_axis_tvalid, 0);

    // first-record latency: tvalid low one cycle after the strobe, high two cycles after
    fire(3'b001, 3'b000, 1'b1, 1'b1, 64'h0000_0001_0000_0010, 1'b1, 16'd0);
    check("lat_tvalid_1", m_axis_tvalid, 0);
    step(1);
    check("lat_tvalid_2", m_axis_tvalid, 1);
    check("lat_b1_data", m_axis_tdata, 32'h0000_0010);
    wait_drain("single", 50);

    for (int i = 0; i < 8; i++) begin
      fire(vecs[i].a, vecs[i].b, vecs[i].en, vecs[i].run, vecs[i].t, vecs[i].kept, 16'd0);
      step(6);
      check($sformatf("vec%0d_tvalid", i), m_axis_tvalid, 0);
      check($sformatf("vec%0d_pending", i), exp_q.size(), 0);
      check($sformatf("vec%0d_occ", i), fifo_occupancy, 0);
    end

    // backpressure mid-B2, then back-to-back streaming of the remaining beats
    m_axis_tready = 1'b0;
    fire(3'b001, 3'b000, 1'b1, 1'b1, 64'h0000_00B1_0000_00A1, 1'b1, 16'd0);
    fire(3'b010, 3'b000, 1'b1, 1'b1, 64'h0000_00B2_0000_00A2, 1'b1, 16'd0);
    fire(3'b000, 3'b100, 1'b1, 1'b1, 64'h0000_00B3_0000_00A3, 1'b1, 16'd0);
    step(2);
    check("bp_occ", fifo_occupancy, 2);
    check("bp_hold_b1", m_axis_tdata, 32'h0000_00A1);
    m_axis_tready = 1'b1;
    step(1);
    m_axis_tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("bp_b2_data", m_axis_tdata, 32'h0000_00B1);
      check("bp_b2_valid", m_axis_tvalid, 1);
    end
    m_axis_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("b2b_valid", m_axis_tvalid, 1);
      step(1);
    end
    check("b2b_end_valid", m_axis_tvalid, 0);
    wait_drain("bp", 20);

    // overflow: first record sits in the output register, 4 fill the FIFO, 2 are dropped
    m_axis_tready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      fire(3'b001, 3'b000, 1'b1, 1'b1, 64'h0000_0C00_0000_0100 + 64'(i), (i < 5),
           (i == 1) ? 16'd2 : 16'd0);
    end
    step(1);
    check("ovf_occ", fifo_occupancy, 4);
    check("ovf_flag", overflow, 1);
    m_axis_tready = 1'b1;
    wait_drain("ovf", 60);
    check("ovf_sticky", overflow, 1);

    // srst during B2 with two records queued
    m_axis_tready = 1'b0;
    fire(3'b001, 3'b000, 1'b1, 1'b1, 64'h0000_0D01_0000_0201, 1'b1, 16'd0);
    fire(3'b010, 3'b000, 1'b1, 1'b1, 64'h0000_0D02_0000_0202, 1'b1, 16'd0);
    fire(3'b100, 3'b000, 1'b1, 1'b1, 64'h0000_0D03_0000_0203, 1'b1, 16'd0);
    step(1);
    m_axis_tready = 1'b1;
    step(1);
    m_axis_tready = 1'b0;
    check("srst_pre_b2", m_axis_tdata, 32'h0000_0D01);
    check("srst_pre_occ", fifo_occupancy, 2);
    srst = 1'b1;
    step(1);
    srst = 1'b0;
    check("srst_tvalid", m_axis_tvalid, 0);
    check("srst_tdata", m_axis_tdata, 0);
    check("srst_occ", fifo_occupancy, 0);
    check("srst_overflow", overflow, 0);
    m_axis_tready = 1'b1;
    step(3);
    check("srst_quiet", m_axis_tvalid, 0);
    fire(3'b000, 3'b011, 1'b1, 1'b1, 64'h0000_0E00_0000_0300, 1'b1, 16'd0);
    wait_drain("srst_next", 30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
